// File: rtl/echo_fb_delay.sv
// -----------------------------------------------------------------------------
// echo_fb_delay
// Feedback (IIR) echo for the mono audio sample path. Each accepted sample x
// reads the delay line D samples back (d), writes w = x + fb*d back into the
// line and emits y = x + mix*d two cycles after acceptance. A clear FSM zeroes
// the whole delay line after reset and on every cfg_flush pulse; samples are
// only accepted once the line is clean.
//
// Optional feature macro: ECHO_SATURATE_EN
//   defined   : w and y saturate to the signed DATA_W range
//   undefined : w and y wrap (low DATA_W bits of the sum)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid          input sample strobe
//   in_sample         dry sample x (signed)
//   in_ready          1 while running and not flushing; samples accepted
//   out_valid         one-cycle output strobe
//   out_sample        y = x + mix*d (x when bypassed); holds between strobes
//   cfg_delay         echo delay in samples, values below 2 act as 2
//   cfg_fb_gain       feedback gain, unsigned Q0.GAIN_W
//   cfg_mix_gain      wet-mix gain, unsigned Q0.GAIN_W
//   cfg_bypass        output the dry sample; delay line still updated
//   cfg_flush         one-cycle pulse that restarts the delay-line clear
// -----------------------------------------------------------------------------
module echo_fb_delay #(
  parameter int  DATA_W    = 16,
  parameter int  MAX_DELAY = 4096,
  parameter int  GAIN_W    = 8,
  localparam int AW        = $clog2(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  input  logic [AW-1:0]     cfg_delay,
  input  logic [GAIN_W-1:0] cfg_fb_gain,
  input  logic [GAIN_W-1:0] cfg_mix_gain,
  input  logic              cfg_bypass,
  input  logic              cfg_flush
);

`ifdef ECHO_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam int PW = DATA_W + GAIN_W + 1;

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_clr_addr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_s1_addr;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_x;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_sample;
  logic [DATA_W-1:0] r_mem [MAX_DELAY];

  logic              w_accept;
  logic              w_s2_fire;
  logic [AW-1:0]     w_delay;
  logic [AW-1:0]     w_rd_addr;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic signed [PW-1:0] w_d_ext;
  logic signed [PW-1:0] w_fb_ext;
  logic signed [PW-1:0] w_mix_ext;
  logic signed [PW-1:0] w_fb_prod;
  logic signed [PW-1:0] w_mix_prod;
  logic [DATA_W:0]   w_w_sum;
  logic [DATA_W:0]   w_y_sum;
  logic [DATA_W-1:0] w_w_red;
  logic [DATA_W-1:0] w_y_red;
  logic              w_unused;

  // Reduce a DATA_W+1 bit sum to DATA_W bits: clamp on overflow when
  // saturation is built in, otherwise keep the low bits.
  function automatic logic [DATA_W-1:0] reduce_sum(input logic [DATA_W:0] s);
    logic ovf;
    ovf = s[DATA_W] ^ s[DATA_W-1];
    if (SAT_EN && ovf) begin
      reduce_sum = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      reduce_sum = s[DATA_W-1:0];
    end
  endfunction

  assign in_ready   = (r_state == ST_RUN) && !cfg_flush;
  assign w_accept   = in_valid && in_ready;
  // A flush kills the sample sitting in stage 2 (no write, no strobe).
  assign w_s2_fire  = r_s1_valid && !cfg_flush;
  assign w_delay    = (cfg_delay < AW'(2)) ? AW'(2) : cfg_delay;
  // r_wr_ptr already points at this sample's own slot; natural AW-bit wrap.
  assign w_rd_addr  = r_wr_ptr - w_delay;

  // Signed d times zero-extended gain; the product always fits PW bits, and
  // dropping the low GAIN_W bits is an arithmetic (floor) shift.
  assign w_d_ext    = {{(GAIN_W+1){r_rd_data[DATA_W-1]}}, r_rd_data};
  assign w_fb_ext   = {{(DATA_W+1){1'b0}}, cfg_fb_gain};
  assign w_mix_ext  = {{(DATA_W+1){1'b0}}, cfg_mix_gain};
  assign w_fb_prod  = w_d_ext * w_fb_ext;
  assign w_mix_prod = w_d_ext * w_mix_ext;
  assign w_w_sum    = {r_s1_x[DATA_W-1], r_s1_x} + w_fb_prod[PW-1:GAIN_W];
  assign w_y_sum    = {r_s1_x[DATA_W-1], r_s1_x} + w_mix_prod[PW-1:GAIN_W];
  assign w_w_red    = reduce_sum(w_w_sum);
  assign w_y_red    = reduce_sum(w_y_sum);
  assign w_unused   = ^{w_fb_prod[GAIN_W-1:0], w_mix_prod[GAIN_W-1:0]};

  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;

  // Delay-line write port: the clearer owns it in CLEAR, stage 2 in RUN.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_s1_addr;
    w_mem_data = w_w_red;
    if (rst) begin
      w_mem_we = 1'b0;
    end else if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_addr;
      w_mem_data = '0;
    end else if (w_s2_fire) begin
      w_mem_we = 1'b1;
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // Delay-line RAM with one write port and a registered read port.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Clear FSM, sample pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_clr_addr   <= '0;
      r_wr_ptr     <= '0;
      r_s1_addr    <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_x       <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else begin
      r_out_valid <= w_s2_fire;
      if (w_s2_fire) begin
        r_out_sample <= cfg_bypass ? r_s1_x : w_y_red;
      end
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_x    <= in_sample;
        r_s1_addr <= r_wr_ptr;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      case (r_state)
        ST_CLEAR: begin
          if (cfg_flush) begin
            r_clr_addr <= '0;
          end else if (r_clr_addr == AW'(MAX_DELAY - 1)) begin
            r_clr_addr <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_clr_addr <= r_clr_addr + AW'(1);
          end
        end
        ST_RUN: begin
          if (cfg_flush) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_addr <= '0;
          r_wr_ptr   <= '0;
        end
      endcase
    end
  end

endmodule
